// File: rtl/telemetry_value_parser_if.sv
// rtl/telemetry_value_parser_if.sv - byte stream in, decoded value array and event pulses out
interface telemetry_value_parser_if #(
  parameter int NUM_SIGNALS = 7,
  parameter int VALUE_WIDTH = 9
);
  localparam int IDX_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;

  logic                                      in_valid;
  logic [7:0]                                in_data;
  logic                                      in_ready;
  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]   value;
  logic                                      update_strobe;
  logic [IDX_W-1:0]                          update_index;
  logic                                      saturated;
  logic                                      error_pulse;

  modport master (
    output in_valid, in_data,
    input  in_ready, value, update_strobe, update_index, saturated, error_pulse
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, value, update_strobe, update_index, saturated, error_pulse
  );
endinterface

// File: rtl/telemetry_value_parser.sv
// rtl/telemetry_value_parser.sv - parses "<idx>:<digits><CR|LF>" lines into value registers
module telemetry_value_parser #(
  parameter int NUM_SIGNALS = 7,
  parameter int VALUE_WIDTH = 9,
  parameter int MAX_DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  telemetry_value_parser_if.slave bus
);
  localparam int IDX_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
  localparam int ACC_W = VALUE_WIDTH + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] VMAX = {4'b0000, {VALUE_WIDTH{1'b1}}};

  typedef enum logic [2:0] {IDLE, COLON, SPACE, DIGITS, COMMIT, DRAIN} state_t;

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [ACC_W-1:0]                        acc_q, acc_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    sat_q, sat_d;
  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] value_q, value_d;
  logic                                    strobe_q, strobe_d;
  logic [IDX_W-1:0]                        uidx_q, uidx_d;
  logic                                    usat_q, usat_d;
  logic                                    err_q, err_d;

  logic             fire, is_term, is_digit, bad, clamp;
  logic [3:0]       digit;
  logic [ACC_W-1:0] prod, acc_sum;

  assign bus.in_ready      = (state_q != COMMIT);
  assign bus.value         = value_q;
  assign bus.update_strobe = strobe_q;
  assign bus.update_index  = uidx_q;
  assign bus.saturated     = usat_q;
  assign bus.error_pulse   = err_q;

  assign fire     = bus.in_valid && bus.in_ready;
  assign is_term  = (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign digit    = bus.in_data[3:0];

  // Accumulator is wide enough that acc*10+9 never wraps, so the clamp sees the true sum
  assign prod    = acc_q * ACC_W'(10) + ACC_W'(digit);
  assign clamp   = (prod > VMAX);
  assign acc_sum = clamp ? VMAX : prod;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    value_d  = value_q;
    strobe_d = 1'b0;
    uidx_d   = uidx_q;
    usat_d   = 1'b0;
    err_d    = 1'b0;
    bad      = 1'b0;

    case (state_q)
      IDLE: if (fire) begin
        if (is_digit && (int'(digit) < NUM_SIGNALS)) begin
          idx_d   = digit[IDX_W-1:0];
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = COLON;
        end else if (!is_term) begin
          bad = 1'b1;
        end
      end
      COLON: if (fire) begin
        if (bus.in_data == 8'h3A) state_d = SPACE;
        else                      bad     = 1'b1;
      end
      SPACE: if (fire) begin
        if (bus.in_data == 8'h20) begin
          state_d = SPACE;
        end else if (is_digit) begin
          acc_d   = acc_sum;
          sat_d   = sat_q | clamp;
          cnt_d   = cnt_q + 1'b1;
          state_d = DIGITS;
        end else begin
          bad = 1'b1;
        end
      end
      DIGITS: if (fire) begin
        if (is_digit && (cnt_q < CNT_W'(MAX_DIGITS))) begin
          acc_d = acc_sum;
          sat_d = sat_q | clamp;
          cnt_d = cnt_q + 1'b1;
        end else if (is_term && !is_digit) begin
          state_d = COMMIT;
        end else begin
          bad = 1'b1;
        end
      end
      COMMIT: begin
        value_d[idx_q] = acc_q[VALUE_WIDTH-1:0];
        strobe_d       = 1'b1;
        uidx_d         = idx_q;
        usat_d         = sat_q;
        state_d        = IDLE;
      end
      DRAIN: if (fire && is_term) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A terminator ends the line immediately; anything else leaves the rest of the line to drain
    if (bad) begin
      err_d   = 1'b1;
      state_d = is_term ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      value_q  <= '0;
      strobe_q <= 1'b0;
      uidx_q   <= '0;
      usat_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      value_q  <= value_d;
      strobe_q <= strobe_d;
      uidx_q   <= uidx_d;
      usat_q   <= usat_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_telemetry_value_parser.sv
// tb/tb_telemetry_value_parser.sv - directed and random line streams against a string-level model
module tb_telemetry_value_parser;
  localparam int NS   = 7;
  localparam int VW   = 9;
  localparam int VMAX = (1 << VW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  telemetry_value_parser_if #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW)) ifc ();

  telemetry_value_parser #(.NUM_SIGNALS(NS), .VALUE_WIDTH(VW), .MAX_DIGITS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int errors = 0;
  int checks = 0;
  int exp_val [NS];

  int n_strobe = 0, n_err = 0, n_nrdy = 0, n_both = 0;
  int last_idx = 0, last_sat = 0;

  always @(negedge clk) begin
    if (ifc.update_strobe) begin
      n_strobe++;
      last_idx = int'(ifc.update_index);
      last_sat = int'(ifc.saturated);
    end
    if (ifc.error_pulse) n_err++;
    if (!ifc.in_ready) n_nrdy++;
    if (ifc.update_strobe && ifc.error_pulse) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_values(input string tag);
    for (int i = 0; i < NS; i++)
      check($sformatf("%s value[%0d]", tag, i), 32'(ifc.value[i]), exp_val[i]);
  endtask

  task automatic send_byte(input byte b);
    int t = 0;
    bit done = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    while (!done) begin
      @(negedge clk);
      if (ifc.in_ready) done = 1;
      else if (++t > 20) begin
        check("handshake timeout", 1, 0);
        ifc.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (gap > 0) begin
        ifc.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(s[i]);
    end
  endtask

  task automatic idle(input int n);
    ifc.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outcome of one line body (terminator excluded): 0 nothing, 1 commit, 2 error
  task automatic model_line(input string body, output int kind, output int idx,
                            output int val, output int sat);
    int n = body.len();
    int p, k;
    longint num;
    kind = 2; idx = 0; val = 0; sat = 0;
    if (n == 0) begin kind = 0; return; end
    if (body[0] < 8'h30 || body[0] >= 8'h30 + NS) return;
    if (n < 2 || body[1] != ":") return;
    p = 2;
    while (p < n && body[p] == " ") p++;
    k = 0; num = 0;
    while (p < n && body[p] >= 8'h30 && body[p] <= 8'h39) begin
      num = num * 10 + (body[p] - 8'h30);
      k++; p++;
    end
    if (k == 0 || k > 3 || p != n) return;
    kind = 1;
    idx  = body[0] - 8'h30;
    val  = (num > VMAX) ? VMAX : int'(num);
    sat  = (num > VMAX) ? 1 : 0;
  endtask

  task automatic run_line(input string body, input string term, input int maxgap);
    int kind, idx, val, sat;
    int s0 = n_strobe, e0 = n_err;
    model_line(body, kind, idx, val, sat);
    send_str({body, term}, maxgap);
    idle(4);
    check({"strobes ", body}, n_strobe - s0, (kind == 1) ? 1 : 0);
    check({"errors ", body}, n_err - e0, (kind == 2) ? 1 : 0);
    if (kind == 1) begin
      exp_val[idx] = val;
      check({"index ", body}, last_idx, idx);
      check({"saturated ", body}, last_sat, sat);
    end
    check_values(body);
  endtask

  initial begin
    int s0, e0, r0;
    string body, term;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    for (int i = 0; i < NS; i++) exp_val[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset strobe", ifc.update_strobe, 0);
    check("reset error", ifc.error_pulse, 0);
    check("reset saturated", ifc.saturated, 0);
    check("reset index", 32'(ifc.update_index), 0);
    check_values("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after reset", ifc.in_ready, 1);

    // Exact commit latency on "3:  42\n"
    send_str("3:  42", 0);
    send_byte(8'h0A);
    check("commit cycle ready", ifc.in_ready, 0);
    check("commit cycle strobe", ifc.update_strobe, 0);
    @(posedge clk);
    #1;
    check("latency strobe", ifc.update_strobe, 1);
    check("latency index", 32'(ifc.update_index), 3);
    check("latency saturated", ifc.saturated, 0);
    check("latency value3", 32'(ifc.value[3]), 42);
    check("latency ready", ifc.in_ready, 1);
    exp_val[3] = 42;
    idle(1);
    check("strobe one cycle", ifc.update_strobe, 0);
    check_values("after 3:42");

    // Back-to-back with valid held high and a CRLF pair
    s0 = n_strobe; e0 = n_err; r0 = n_nrdy;
    send_str("0:511\r\n6:7\n", 0);
    idle(4);
    check("b2b ready-low cycles", n_nrdy - r0, 2);
    check("b2b strobes", n_strobe - s0, 2);
    check("b2b errors", n_err - e0, 0);
    exp_val[0] = 511;
    exp_val[6] = 7;
    check_values("b2b");

    run_line("1:600", "\n", 0);
    run_line("1:1234", "\n", 0);
    run_line("2:x5", "\n", 0);
    run_line("7:5", "\n", 0);
    run_line("4:", "\n", 0);

    // Reset in the middle of a line
    send_str("5:12", 0);
    ifc.in_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    for (int i = 0; i < NS; i++) exp_val[i] = 0;
    check("midreset strobe", ifc.update_strobe, 0);
    check("midreset error", ifc.error_pulse, 0);
    check("midreset saturated", ifc.saturated, 0);
    check("midreset index", 32'(ifc.update_index), 0);
    check_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    run_line("5:9", "\n", 0);
    run_line("2:100", "\n", 3);

    // Random lines, some well-formed, some not
    for (int n = 0; n < 40; n++) begin
      int nd = $urandom_range(0, 4);
      body = "";
      if ($urandom_range(0, 9) == 0) body = "x";
      else body = {body, string'(byte'(8'h30 + $urandom_range(0, 9)))};
      if ($urandom_range(0, 9) != 0) body = {body, ":"};
      repeat ($urandom_range(0, 2)) body = {body, " "};
      repeat (nd) body = {body, string'(byte'(8'h30 + $urandom_range(0, 9)))};
      if ($urandom_range(0, 9) == 0) body = {body, "-"};
      term = $urandom_range(0, 1) ? "\n" : "\r";
      run_line(body, term, $urandom_range(0, 2));
    end

    check("strobe and error never together", n_both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
